// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: iterative shifter, one bit position per cycle.
// Handles SLL/SRL/SRA/pass with valid/ready on both sides.
module iter_shift_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  =
    {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_nx;
  logic [1:0]             op_q;
  logic [1:0]             op_nx;
  logic [DATA_WIDTH-1:0]  work;
  logic [DATA_WIDTH-1:0]  work_nx;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [SHAMT_WIDTH-1:0] cnt_nx;
  logic [DATA_WIDTH-1:0]  step;
  logic                   skip;

  // the single 1-bit shift stage, reused every SHIFT cycle
  always_comb begin
    step = work;
    unique case (op_q)
      OP_SLL:  step = {work[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work[DATA_WIDTH-1:1]};
      OP_SRA:  step = {work[DATA_WIDTH-1],
                       work[DATA_WIDTH-1:1]};
      OP_PASS: step = work;
    endcase
  end

  assign skip = (shamt == CNT_ZERO) || (op == OP_PASS);

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    work_nx  = work;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_nx    = op;
            work_nx  = din;
            cnt_nx   = shamt;
            state_nx = skip ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work_nx = step;
          // saturate at zero so the counter can never wrap
          if (cnt != CNT_ZERO) begin
            cnt_nx = cnt - CNT_ONE;
          end
          if (cnt <= CNT_ONE) begin
            state_nx = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= OP_SLL;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      work  <= work_nx;
      cnt   <= cnt_nx;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dout      = work;

endmodule

// File: doc/iter_shift_ctrl.md
ITER_SHIFT_CTRL -- requirements
Module: iter_shift_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_WIDTH, default 5, shift-amount width (2^SHAMT_WIDTH = DATA_WIDTH).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  abort current operation (pipeline flush).
REQ-007 in_valid  input  1  request carries valid op/din/shamt.
REQ-008 in_ready  output  1  controller can accept a request.
REQ-009 op  input  2  00 SLL, 01 SRL, 11 SRA, 10 pass-through.
REQ-010 din  input  DATA_WIDTH  operand.
REQ-011 shamt  input  SHAMT_WIDTH  shift amount, unsigned.
REQ-012 dout  output  DATA_WIDTH  result.
REQ-013 out_valid  output  1  dout holds a completed result.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 busy  output  1  operation in progress or result pending (pipeline stall).

Function
REQ-016 SHALL sequence a single 1-bit shift stage repeatedly: one bit position per cycle, no barrel shifter.
REQ-017 SHALL implement states IDLE, SHIFT, DONE.
REQ-018 IDLE: in_ready=1; accept when in_valid=1; latch op, load work register with din, counter with shamt.
REQ-019 On accept: shamt=0 or op=10 -> DONE next cycle; else -> SHIFT.
REQ-020 SHIFT, each cycle: SLL -> {w[DATA_WIDTH-2:0],0}; SRL -> {0,w[DATA_WIDTH-1:1]}; SRA -> {w[DATA_WIDTH-1],w[DATA_WIDTH-1:1]}; counter decrements by 1.
REQ-021 SHIFT -> DONE in the same cycle the counter transitions 1 -> 0.
REQ-022 Latency: out_valid asserts exactly shamt+1 cycles after the accept edge (1 cycle for shamt=0 or op=10).
REQ-023 DONE: out_valid=1, dout = work register, held stable while out_ready=0.
REQ-024 DONE with out_ready=1 -> IDLE next cycle; new request accepted no earlier than the cycle after return to IDLE.
REQ-025 in_ready=1 only in IDLE; in_valid outside IDLE ignored, op/din/shamt changes outside IDLE have no effect.
REQ-026 out_valid=1 only in DONE; dout undefined-but-stable (work register) otherwise, not to be sampled.
REQ-027 busy=1 in SHIFT and DONE, 0 in IDLE.
REQ-028 flush=1 in any state -> IDLE next cycle, result discarded, out_valid=0 next cycle; flush in IDLE with in_valid=1 -> request NOT accepted.
REQ-029 Priority: rst > flush > normal operation.
REQ-030 Shift amount DATA_WIDTH-1 (max) SHALL complete correctly; counter SHALL NOT wrap.

Reset
REQ-031 rst=1 at a clock edge -> state IDLE, counter 0, work register 0, op latch 00.
REQ-032 After reset: in_ready=1, out_valid=0, busy=0, dout=0.
REQ-033 rst mid-SHIFT or in DONE SHALL abandon the operation with no result delivered.

Verification
REQ-034 SLL din=0x00000001 shamt=31, out_ready=1 -> out_valid 32 cycles after accept, dout=0x80000000, busy high 32 cycles.
REQ-035 SRA din=0x80000000 shamt=4 -> dout=0xF8000000 after 5 cycles; SRL same inputs -> dout=0x08000000.
REQ-036 shamt=0, op=SLL, din=0xDEADBEEF -> dout=0xDEADBEEF, out_valid 1 cycle after accept; op=10 shamt=7 same din -> 0xDEADBEEF in 1 cycle.
REQ-037 Backpressure: SRL din=0xF0000000 shamt=8, out_ready=0 for 5 cycles in DONE -> dout=0x00F00000 stable, out_valid held, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 flush on 3rd SHIFT cycle of shamt=10 -> IDLE next cycle, out_valid never asserted; following SLL din=0x3 shamt=2 -> 0xC.
REQ-039 rst asserted mid-SHIFT -> next cycle in_ready=1, busy=0, out_valid=0, dout=0.
